// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants, clear-FSM state encoding and the effective-write
// predicate used by the multi-port register file.
package gpr_pkg;

    localparam int unsigned GPR_DW = 32;
    localparam int unsigned GPR_AW = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // A write port commits only when enabled, not overflowed, not aimed at a
    // hardwired-zero entry, and the clear engine is not running.
    function automatic logic wr_eff(input logic en,
                                    input logic ovf,
                                    input logic zero_hit,
                                    input logic idle);
        return en & ~ovf & ~zero_hit & idle;
    endfunction

endpackage

// File: rtl/gpr_if.sv
// gpr_if: read ports, two write ports, overflow status and bulk-clear control
// of the register file.
//   ra/rd                 : NRD packed read addresses / read data
//   w0_*/w1_*             : write ports (port 1 is the younger instruction)
//   ovf_clr/ovf_flag/ovf_addr : sticky overflow status
//   clr_req/clr_busy      : bulk-clear request and progress
interface gpr_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 5,
    parameter int unsigned NRD = 2
);
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic              w0_en;
    logic [AW-1:0]     w0_addr;
    logic [DW-1:0]     w0_data;
    logic              w0_ovf;
    logic              w1_en;
    logic [AW-1:0]     w1_addr;
    logic [DW-1:0]     w1_data;
    logic              w1_ovf;
    logic              ovf_clr;
    logic              ovf_flag;
    logic [AW-1:0]     ovf_addr;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output ra, w0_en, w0_addr, w0_data, w0_ovf,
               w1_en, w1_addr, w1_data, w1_ovf, ovf_clr, clr_req,
        input  rd, ovf_flag, ovf_addr, clr_busy
    );

    modport slave (
        input  ra, w0_en, w0_addr, w0_data, w0_ovf,
               w1_en, w1_addr, w1_data, w1_ovf, ovf_clr, clr_req,
        output rd, ovf_flag, ovf_addr, clr_busy
    );
endinterface

// File: rtl/gpr_clr_fsm.sv
// gpr_clr_fsm: sequential bulk-clear engine, zeroes one entry per cycle.
//   clk, rst   : clock, async active-high reset
//   clr_req    : start request (ignored while clearing)
//   clr_busy   : clear in progress
//   clr_we_c   : clear-write strobe for the current cycle
//   clr_addr   : entry zeroed on the next edge
module gpr_clr_fsm
    import gpr_pkg::*;
#(
    parameter int unsigned AW = GPR_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we_c,
    output logic [AW-1:0] clr_addr
);
    localparam int unsigned DEPTH = 1 << AW;

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    // State, counter and busy flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    // Next state: run DEPTH cycles, leave on the edge that clears the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr_busy = busy_q;
    assign clr_we_c = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: multi-port register file with two write ports, NRD combinational
// read ports, optional write-to-read bypass, sticky first-overflow status and
// a bulk-clear engine.
//   clk, rst : clock, async active-high reset
//   bus      : gpr_if slave (read/write ports, overflow status, clear control)
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int unsigned DW       = GPR_DW,
    parameter int unsigned AW       = GPR_AW,
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic clk,
    input  logic rst,
    gpr_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0]     mem [DEPTH];
    logic              clr_we_c;
    logic [AW-1:0]     clr_addr;
    logic              clr_busy;
    logic              we0_c, we1_c;
    logic              ovf0_c, ovf1_c;
    logic              ovf_flag_q;
    logic [AW-1:0]     ovf_addr_q;
    logic [NRD*DW-1:0] rd_c;

    gpr_clr_fsm #(.AW(AW)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_we_c (clr_we_c),
        .clr_addr (clr_addr)
    );

    assign we0_c = wr_eff(bus.w0_en, bus.w0_ovf,
                          (ZERO_REG != 0) && (bus.w0_addr == '0), ~clr_we_c);
    assign we1_c = wr_eff(bus.w1_en, bus.w1_ovf,
                          (ZERO_REG != 0) && (bus.w1_addr == '0), ~clr_we_c);

    // Array: clear write first, then port 1 over port 0 (younger wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_we_c && (clr_addr == AW'(i))) begin
                    mem[i] <= '0;
                end else if (we1_c && (bus.w1_addr == AW'(i))) begin
                    mem[i] <= bus.w1_data;
                end else if (we0_c && (bus.w0_addr == AW'(i))) begin
                    mem[i] <= bus.w0_data;
                end
            end
        end
    end

    // One read port: array value, optionally forwarded, forced zero at entry 0.
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem[a];
        if (BYPASS != 0) begin
            if (we1_c && (bus.w1_addr == a)) begin
                v = bus.w1_data;
            end else if (we0_c && (bus.w0_addr == a)) begin
                v = bus.w0_data;
            end
        end
        if ((ZERO_REG != 0) && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd_c = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_c[k*DW +: DW] = rd_port(bus.ra[k*AW +: AW]);
        end
    end

    assign ovf0_c = bus.w0_en & bus.w0_ovf;
    assign ovf1_c = bus.w1_en & bus.w1_ovf;

    // Sticky overflow: first address is held; a clear coinciding with a new
    // overflow re-arms the capture so the new address is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag_q <= 1'b0;
            ovf_addr_q <= '0;
        end else if (ovf0_c || ovf1_c) begin
            ovf_flag_q <= 1'b1;
            if (!ovf_flag_q || bus.ovf_clr) begin
                ovf_addr_q <= ovf0_c ? bus.w0_addr : bus.w1_addr;
            end
        end else if (bus.ovf_clr) begin
            ovf_flag_q <= 1'b0;
            ovf_addr_q <= '0;
        end
    end

    assign bus.rd       = rd_c;
    assign bus.ovf_flag = ovf_flag_q;
    assign bus.ovf_addr = ovf_addr_q;
    assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: directed self-checking bench for gpr_mp (DW=32, AW=5, NRD=2,
// BYPASS=1, ZERO_REG=1).
module tb_gpr_mp;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;

    gpr_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    gpr_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.w0_en   = 1'b0;
        bus.w0_ovf  = 1'b0;
        bus.w0_addr = '0;
        bus.w0_data = '0;
        bus.w1_en   = 1'b0;
        bus.w1_ovf  = 1'b0;
        bus.w1_addr = '0;
        bus.w1_data = '0;
        bus.ovf_clr = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    task automatic rd_at(input int a0, input int a1);
        bus.ra = {AW'(a1), AW'(a0)};
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        bus.ra = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_at(i, DEPTH - 1 - i);
            chk("rst_rd0", bus.rd[31:0], 0);
            chk("rst_rd1", bus.rd[63:32], 0);
        end
        chk("rst_flag", bus.ovf_flag, 0);
        chk("rst_oaddr", bus.ovf_addr, 0);
        chk("rst_busy", bus.clr_busy, 0);
        tick();

        // Dual write to same address: younger wins, bypassed same cycle
        bus.w0_en = 1; bus.w0_addr = 5; bus.w0_data = 32'h11111111;
        bus.w1_en = 1; bus.w1_addr = 5; bus.w1_data = 32'h22222222;
        rd_at(5, 5);
        chk("dual_byp0", bus.rd[31:0], 32'h22222222);
        chk("dual_byp1", bus.rd[63:32], 32'h22222222);
        tick();
        idle_in();
        rd_at(5, 5);
        chk("dual_after", bus.rd[31:0], 32'h22222222);

        // Distinct addresses on both ports
        bus.w0_en = 1; bus.w0_addr = 1; bus.w0_data = 32'h00000101;
        bus.w1_en = 1; bus.w1_addr = 2; bus.w1_data = 32'h00000202;
        rd_at(1, 2);
        chk("split_byp0", bus.rd[31:0], 32'h101);
        chk("split_byp1", bus.rd[63:32], 32'h202);
        tick();
        idle_in();
        rd_at(2, 1);
        chk("split_rd0", bus.rd[31:0], 32'h202);
        chk("split_rd1", bus.rd[63:32], 32'h101);

        // Entry 0 hardwired to zero
        bus.w0_en = 1; bus.w0_addr = 0; bus.w0_data = 32'hDEADBEEF;
        rd_at(0, 0);
        chk("z0_same", bus.rd[31:0], 0);
        tick();
        idle_in();
        rd_at(0, 0);
        chk("z0_after", bus.rd[63:32], 0);

        // Overflow: write suppressed, first address captured
        bus.w0_en = 1; bus.w0_ovf = 1; bus.w0_addr = 7; bus.w0_data = 32'h5;
        rd_at(7, 7);
        chk("ovf_nobyp", bus.rd[31:0], 0);
        tick();
        idle_in();
        rd_at(7, 7);
        chk("ovf_nowr", bus.rd[31:0], 0);
        chk("ovf_flag1", bus.ovf_flag, 1);
        chk("ovf_addr7", bus.ovf_addr, 7);
        bus.w1_en = 1; bus.w1_ovf = 1; bus.w1_addr = 9; bus.w1_data = 32'h9;
        tick();
        idle_in();
        rd_at(9, 9);
        chk("ovf_hold", bus.ovf_addr, 7);
        chk("ovf_nowr9", bus.rd[63:32], 0);
        bus.ovf_clr = 1; bus.w0_en = 1; bus.w0_ovf = 1; bus.w0_addr = 3;
        tick();
        idle_in();
        chk("ovf_setwin_f", bus.ovf_flag, 1);
        chk("ovf_setwin_a", bus.ovf_addr, 3);
        bus.ovf_clr = 1;
        tick();
        idle_in();
        chk("ovf_clr_f", bus.ovf_flag, 0);
        chk("ovf_clr_a", bus.ovf_addr, 0);
        bus.w0_en = 1; bus.w0_ovf = 1; bus.w0_addr = 10;
        bus.w1_en = 1; bus.w1_ovf = 1; bus.w1_addr = 11;
        tick();
        idle_in();
        chk("ovf_both", bus.ovf_addr, 10);

        // Fill then bulk clear
        for (int i = 1; i < int'(DEPTH); i++) begin
            bus.w0_en = 1; bus.w0_addr = AW'(i); bus.w0_data = 32'hA5A5A5A5;
            tick();
        end
        idle_in();
        rd_at(31, 4);
        chk("fill_31", bus.rd[31:0], 32'hA5A5A5A5);
        bus.clr_req = 1;
        tick();
        n = 0;
        while (bus.clr_busy && n < 100) begin
            idle_in();
            if (n == 5) begin
                bus.ovf_clr = 1; bus.w1_en = 1; bus.w1_ovf = 1; bus.w1_addr = 13;
            end
            if (n == 10) begin
                rd_at(9, 10);
                chk("mid_done", bus.rd[31:0], 0);
                chk("mid_pend", bus.rd[63:32], 32'hA5A5A5A5);
            end
            if (n == 20) begin
                bus.w0_en = 1; bus.w0_addr = 4; bus.w0_data = 32'h44;
                rd_at(4, 4);
                chk("clr_nobyp", bus.rd[31:0], 0);
            end
            n++;
            tick();
        end
        idle_in();
        chk("clr_len", n, 32);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_at(i, (i + 7) % DEPTH);
            chk("clr_rd0", bus.rd[31:0], 0);
            chk("clr_rd1", bus.rd[63:32], 0);
        end
        chk("clr_ovf_f", bus.ovf_flag, 1);
        chk("clr_ovf_a", bus.ovf_addr, 13);
        tick();

        // Reset in the middle of a clear
        bus.w0_en = 1; bus.w0_addr = 12; bus.w0_data = 32'h5A5A5A5A;
        bus.w1_en = 1; bus.w1_addr = 20; bus.w1_data = 32'h77777777;
        tick();
        idle_in();
        rd_at(12, 20);
        chk("pre_rd12", bus.rd[31:0], 32'h5A5A5A5A);
        chk("pre_rd20", bus.rd[63:32], 32'h77777777);
        bus.clr_req = 1;
        tick();
        idle_in();
        repeat (10) tick();
        chk("mid_busy", bus.clr_busy, 1);
        rst = 1'b1;
        rd_at(12, 20);
        chk("rstm_busy", bus.clr_busy, 0);
        chk("rstm_rd12", bus.rd[31:0], 0);
        chk("rstm_rd20", bus.rd[63:32], 0);
        chk("rstm_flag", bus.ovf_flag, 0);
        tick();
        rst = 1'b0;
        bus.w0_en = 1; bus.w0_addr = 12; bus.w0_data = 32'h12345678;
        tick();
        idle_in();
        rd_at(12, 12);
        chk("post_rd12", bus.rd[31:0], 32'h12345678);
        chk("post_busy", bus.clr_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
